// File: rtl/rv32_types.sv
// rtl/rv32_types.sv - shared register-file types and FSM state encoding
package rv32_types;

   typedef logic [4:0]  rv_reg_id_t;
   typedef logic [31:0] rv32_word;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_READY = 1'b1
   } rv32_rf_state_t;

endpackage

// File: rtl/rv32_rf_write_merge.sv
// rtl/rv32_rf_write_merge.sv - per-entry write enable/data after port collision resolution
// Ports are scanned in ascending order so the highest-index enabled port wins an entry.
module rv32_rf_write_merge
   import rv32_types::*;
#(
   parameter int NUM_WR = 2,
   parameter int XLEN   = 32,
   parameter int NREGS  = 32
) (
   input  logic [NUM_WR-1:0]                 we,
   input  logic [NUM_WR*$clog2(NREGS)-1:0]   rw,
   input  logic [NUM_WR*XLEN-1:0]            d,
   output logic [NREGS-1:0]                  entry_we,
   output logic [NREGS*XLEN-1:0]             entry_data
);

   localparam int IW = $clog2(NREGS);

   always_comb begin
      entry_we   = '0;
      entry_data = '0;
      for (int e = 0; e < NREGS; e++) begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (we[p] && rw[p*IW +: IW] == IW'(e)) begin
               entry_we[e]                 = 1'b1;
               entry_data[e*XLEN +: XLEN]  = d[p*XLEN +: XLEN];
            end
         end
      end
   end

endmodule

// File: rtl/rv32_multiport_register_file.sv
// rtl/rv32_multiport_register_file.sv - multiport register file with clear-sweep FSM
// Define RV32_RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module rv32_multiport_register_file
   import rv32_types::*;
#(
   parameter int NUM_RD   = 3,
   parameter int NUM_WR   = 2,
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_RD*$clog2(NREGS)-1:0]   rs,
   output logic [NUM_RD*XLEN-1:0]            o,
   input  logic [NUM_WR-1:0]                 we,
   input  logic [NUM_WR*$clog2(NREGS)-1:0]   rw,
   input  logic [NUM_WR*XLEN-1:0]            d,
   input  logic                              clear_req,
   output logic                              ready
);

   localparam int IW = $clog2(NREGS);

   rv32_rf_state_t          state, state_next;
   logic [IW-1:0]           clr_idx, clr_idx_next;
   logic [XLEN-1:0]         mem [NREGS];
   logic [NREGS-1:0]        merge_we;
   logic [NREGS*XLEN-1:0]   merge_data;
   logic                    active;

   rv32_rf_write_merge #(
      .NUM_WR (NUM_WR),
      .XLEN   (XLEN),
      .NREGS  (NREGS)
   ) u_write_merge (
      .we         (we),
      .rw         (rw),
      .d          (d),
      .entry_we   (merge_we),
      .entry_data (merge_data)
   );

   // Reset also masks reads and writes combinationally so nothing leaks while rst is held.
   assign active = (state == RF_READY) && !rst;
   assign ready  = active;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RF_CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_next;
         clr_idx <= clr_idx_next;
      end
   end

   always_comb begin
      state_next   = state;
      clr_idx_next = clr_idx;
      case (state)
         RF_CLEAR: begin
            clr_idx_next = clr_idx + IW'(1);
            if (clr_idx == IW'(NREGS - 1)) begin
               state_next = RF_READY;
            end
         end
         RF_READY: begin
            if (clear_req) begin
               state_next   = RF_CLEAR;
               clr_idx_next = '0;
            end
         end
         default: begin
            state_next   = RF_CLEAR;
            clr_idx_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      for (int e = 0; e < NREGS; e++) begin
         if (state == RF_CLEAR) begin
            if (clr_idx == IW'(e)) begin
               mem[e] <= '0;
            end
         end else if (active && merge_we[e] && !(ZERO_REG != 0 && e == 0)) begin
            mem[e] <= merge_data[e*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      o = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (active && !(ZERO_REG != 0 && rs[i*IW +: IW] == '0)) begin
            o[i*XLEN +: XLEN] = mem[rs[i*IW +: IW]];
`ifdef RV32_RF_BYPASS_EN
            if (merge_we[rs[i*IW +: IW]]) begin
               o[i*XLEN +: XLEN] = merge_data[int'(rs[i*IW +: IW])*XLEN +: XLEN];
            end
`else
`endif
         end
      end
   end

endmodule
